sr04_echo_emulator: RTL and testbench

// Synthesizable HC-SR04 sensor model: the responder end of the ultrasonic trig/echo interface.

---
 rtl/sr04_echo_emulator.sv | 182 ++++++++++++++++++
 tb/tb_sr04_echo_emulator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr04_echo_emulator.sv
// HC-SR04 responder model: validates a trig pulse, waits the burst delay, then drives an echo whose width encodes cm_in.
// Outputs are registered; reset is asynchronous, and enable=0 returns the block to IDLE on the next clock.
module sr04_echo_emulator #(
  parameter int CLKS_PER_US    = 100,
  parameter int TRIG_MIN_US    = 10,
  parameter int BURST_DELAY_US = 200,
  parameter int US_PER_CM      = 58,
  parameter int MAX_CM         = 400,
  parameter int TIMEOUT_US     = 38000,
  parameter int HOLDOFF_US     = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [11:0] cm_in,
  input  logic        trig,
  output logic        echo,
  output logic        busy,
  output logic        meas_done,
  output logic        trig_err
);

  localparam int CW        = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int TRIG_CLKS = TRIG_MIN_US * CLKS_PER_US;
  localparam int TW        = $clog2(TRIG_CLKS + 1);

  localparam logic [CW-1:0] CLK_LAST    = CW'(CLKS_PER_US - 1);
  localparam logic [TW-1:0] TRIG_SAT    = TW'(TRIG_CLKS);
  localparam logic [11:0]   MAX_CM_L    = 12'(MAX_CM);
  localparam logic [15:0]   BURST_LAST  = 16'(BURST_DELAY_US - 1);
  localparam logic [15:0]   HOLD_LAST   = 16'(HOLDOFF_US - 1);
  localparam logic [15:0]   TIMEOUT_L   = 16'(TIMEOUT_US);
  localparam logic [15:0]   US_PER_CM_L = 16'(US_PER_CM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync3;
  logic [CW-1:0] r_clk_cnt;
  logic [15:0]   r_us_cnt;
  logic [TW-1:0] r_trig_cnt;
  logic [11:0]   r_cm_lat;
  logic          r_echo;
  logic          r_busy;
  logic          r_meas_done;
  logic          r_trig_err;

  logic          w_rise;
  logic          w_fall;
  logic          w_tick;
  logic          w_done;
  logic [15:0]   w_echo_us;
  logic [15:0]   w_last_us;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= trig;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync3;
  assign w_fall = ~r_sync2 & r_sync3;

  // Zero or beyond-range distance reports as "no object" with the timeout width.
  assign w_echo_us = (r_cm_lat == 12'd0 || r_cm_lat > MAX_CM_L) ? TIMEOUT_L
                   : 16'(r_cm_lat) * US_PER_CM_L;

  always_comb begin
    w_last_us = HOLD_LAST;
    case (r_state)
      S_BURST: w_last_us = BURST_LAST;
      S_ECHO:  w_last_us = w_echo_us - 16'd1;
      default: w_last_us = HOLD_LAST;
    endcase
  end

  assign w_tick = (r_clk_cnt == CLK_LAST);
  assign w_done = w_tick && (r_us_cnt == w_last_us);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_us_cnt    <= '0;
      r_trig_cnt  <= '0;
      r_cm_lat    <= '0;
      r_echo      <= 1'b0;
      r_busy      <= 1'b0;
      r_meas_done <= 1'b0;
      r_trig_err  <= 1'b0;
    end else begin
      r_meas_done <= 1'b0;
      r_trig_err  <= 1'b0;
      if (!enable) begin
        r_state    <= S_IDLE;
        r_echo     <= 1'b0;
        r_busy     <= 1'b0;
        r_clk_cnt  <= '0;
        r_us_cnt   <= '0;
        r_trig_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            // The rise cycle itself is the first high clock of the pulse.
            if (w_rise) begin
              r_state    <= S_TRIG;
              r_trig_cnt <= TW'(1);
            end else begin
              r_trig_cnt <= '0;
            end
          end
          S_TRIG: begin
            if (w_fall) begin
              r_trig_cnt <= '0;
              if (r_trig_cnt >= TRIG_SAT) begin
                r_cm_lat <= cm_in;
                r_busy   <= 1'b1;
                r_state  <= S_BURST;
              end else begin
                r_trig_err <= 1'b1;
                r_state    <= S_IDLE;
              end
            end else if (r_trig_cnt != TRIG_SAT) begin
              r_trig_cnt <= r_trig_cnt + TW'(1);
            end
          end
          S_BURST, S_ECHO, S_HOLDOFF: begin
            if (w_done) begin
              r_clk_cnt <= '0;
              r_us_cnt  <= '0;
              case (r_state)
                S_BURST: begin
                  r_echo  <= 1'b1;
                  r_state <= S_ECHO;
                end
                S_ECHO: begin
                  r_echo      <= 1'b0;
                  r_meas_done <= 1'b1;
                  r_state     <= S_HOLDOFF;
                end
                default: begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end
              endcase
            end else if (w_tick) begin
              r_clk_cnt <= '0;
              r_us_cnt  <= r_us_cnt + 16'd1;
            end else begin
              r_clk_cnt <= r_clk_cnt + CW'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_echo  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign echo      = r_echo;
  assign busy      = r_busy;
  assign meas_done = r_meas_done;
  assign trig_err  = r_trig_err;

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// Scoreboard bench for sr04_echo_emulator with scaled-down timing parameters.
// Stimulus pushes expected echo/trig_err events; a monitor checks each DUT event as it appears.
module tb_sr04_echo_emulator;

  localparam int CPU        = 2;
  localparam int TRIG_MIN   = 3;
  localparam int BURST      = 5;
  localparam int UPC        = 3;
  localparam int MAXCM      = 20;
  localparam int TMO        = 100;
  localparam int HOLD       = 7;
  localparam int TRIG_CLKS  = TRIG_MIN * CPU;
  localparam int BURST_CLKS = BURST * CPU;
  localparam int HOLD_CLKS  = HOLD * CPU;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [11:0] cm_in;
  logic        trig;
  logic        echo;
  logic        busy;
  logic        meas_done;
  logic        trig_err;

  typedef enum int {K_ERR, K_ECHO, K_ABORT} kind_t;
  typedef struct {
    kind_t kind;
    int    t_busy;
    int    t_rise;
    int    width;
    int    t_ev;
  } item_t;

  item_t sb[$];
  int    cyc        = 0;
  int    checks     = 0;
  int    errors     = 0;
  int    abort_edge = -1;

  sr04_echo_emulator #(
    .CLKS_PER_US(CPU), .TRIG_MIN_US(TRIG_MIN), .BURST_DELAY_US(BURST),
    .US_PER_CM(UPC), .MAX_CM(MAXCM), .TIMEOUT_US(TMO), .HOLDOFF_US(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cm_in(cm_in), .trig(trig),
    .echo(echo), .busy(busy), .meas_done(meas_done), .trig_err(trig_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL unexp_%s: got event at cycle %0d expected none (queue depth %0d)", name, cyc, sb.size());
  endtask

  function automatic int exp_width(input int cm);
    if (cm == 0 || cm > MAXCM) return TMO * CPU;
    return cm * UPC * CPU;
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drives one trig pulse of w clocks and queues the response the sensor should give.
  task automatic measure(input int cm, input int w, input kind_t ok_kind, input bit strays,
                         output int t_rise);
    item_t it;
    int    e0;
    cm_in = 12'(cm);
    trig  = 1'b1;
    repeat (w) @(negedge clk);
    trig = 1'b0;
    e0   = cyc + 1;
    if (w >= TRIG_CLKS) begin
      it.kind = ok_kind; it.t_busy = e0 + 2; it.t_rise = e0 + 2 + BURST_CLKS;
      it.width = exp_width(cm); it.t_ev = 0;
    end else begin
      it.kind = K_ERR; it.t_busy = 0; it.t_rise = 0; it.width = 0; it.t_ev = e0 + 2;
    end
    sb.push_back(it);
    t_rise = it.t_rise;
    if (it.kind == K_ERR) begin
      wait_until(e0 + 4 + int'($urandom_range(3, 0)));
    end else if (it.kind == K_ECHO) begin
      if (strays && it.width >= 20) begin
        wait_until(it.t_rise + 2);
        trig = 1'b1;
        repeat ($urandom_range(8, 1)) @(negedge clk);
        trig  = 1'b0;
        cm_in = 12'($urandom);
        wait_until(it.t_rise + it.width + 1);
        trig = 1'b1;
        repeat (3) @(negedge clk);
        trig = 1'b0;
      end
      wait_until(it.t_rise + it.width + HOLD_CLKS + 3 + int'($urandom_range(3, 0)));
    end
  endtask

  // Monitor: compares every observable DUT event against the scoreboard front.
  logic  p_echo = 1'b0;
  logic  p_busy = 1'b0;
  int    busy_end_exp = -1;
  bit    aborted;
  item_t mon_it;

  always @(posedge clk) begin
    #1;
    aborted = 1'b0;
    if (meas_done && trig_err) unexpected("done_and_err");
    if (trig_err) begin
      if (sb.size() == 0 || sb[0].kind != K_ERR) unexpected("trig_err");
      else begin
        mon_it = sb.pop_front();
        check("trig_err_time", cyc, mon_it.t_ev);
      end
    end
    if (busy && !p_busy) begin
      if (sb.size() == 0 || sb[0].kind == K_ERR) unexpected("busy_rise");
      else check("busy_rise", cyc, sb[0].t_busy);
    end
    if (echo && !p_echo) begin
      if (sb.size() == 0 || sb[0].kind == K_ERR) unexpected("echo_rise");
      else begin
        check("echo_rise", cyc, sb[0].t_rise);
        check("busy_at_rise", busy, 1);
      end
    end
    if (!echo && p_echo) begin
      if (sb.size() == 0 || sb[0].kind == K_ERR) unexpected("echo_fall");
      else begin
        mon_it = sb.pop_front();
        if (mon_it.kind == K_ECHO) begin
          check("echo_width", cyc - mon_it.t_rise, mon_it.width);
          check("meas_done", meas_done, 1);
          check("busy_in_hold", busy, 1);
          busy_end_exp = cyc + HOLD_CLKS;
        end else begin
          check("abort_edge", cyc, abort_edge);
          check("abort_no_done", meas_done, 0);
          check("abort_busy", busy, 0);
          busy_end_exp = -1;
          aborted = 1'b1;
        end
      end
    end else if (meas_done) begin
      unexpected("meas_done");
    end
    if (!busy && p_busy && !aborted) begin
      if (busy_end_exp >= 0) begin
        check("busy_fall", cyc, busy_end_exp);
        busy_end_exp = -1;
      end else begin
        unexpected("busy_fall");
      end
    end
    p_echo = echo;
    p_busy = busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by cycle %0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int tr;
    int e0;
    int end_b;
    item_t it;
    reset_n = 1'b0; enable = 1'b1; trig = 1'b0; cm_in = 12'd0;
    repeat (3) @(negedge clk);
    check("rst_echo", echo, 0);
    check("rst_busy", busy, 0);
    check("rst_meas_done", meas_done, 0);
    check("rst_trig_err", trig_err, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    measure(10, TRIG_CLKS, K_ECHO, 1'b0, tr);
    measure(5, TRIG_CLKS - 1, K_ECHO, 1'b0, tr);
    measure(5, 1, K_ECHO, 1'b0, tr);
    measure(0, TRIG_CLKS + 2, K_ECHO, 1'b0, tr);
    measure(MAXCM + 1, TRIG_CLKS, K_ECHO, 1'b0, tr);
    measure(MAXCM, TRIG_CLKS, K_ECHO, 1'b0, tr);
    measure(1, TRIG_CLKS, K_ECHO, 1'b0, tr);
    measure(10, TRIG_CLKS + 3, K_ECHO, 1'b1, tr);

    // Synchronous abort, then trig must be ignored while disabled.
    measure(8, TRIG_CLKS + 1, K_ABORT, 1'b0, tr);
    wait_until(tr + 5);
    enable = 1'b0;
    abort_edge = cyc + 1;
    repeat (2) @(negedge clk);
    check("en_echo_low", echo, 0);
    check("en_busy_low", busy, 0);
    trig = 1'b1;
    repeat (TRIG_CLKS + 2) @(negedge clk);
    trig = 1'b0;
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (5) @(negedge clk);

    // Asynchronous reset mid-echo.
    measure(12, TRIG_CLKS, K_ABORT, 1'b0, tr);
    wait_until(tr + 7);
    reset_n = 1'b0;
    abort_edge = cyc + 1;
    #1;
    check("rst_echo_async", echo, 0);
    check("rst_busy_async", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // trig held high across the end of HOLDOFF must not start a measurement.
    cm_in = 12'd4;
    trig = 1'b1;
    repeat (TRIG_CLKS) @(negedge clk);
    trig = 1'b0;
    e0 = cyc + 1;
    it.kind = K_ECHO; it.t_busy = e0 + 2; it.t_rise = e0 + 2 + BURST_CLKS;
    it.width = exp_width(4); it.t_ev = 0;
    sb.push_back(it);
    end_b = it.t_rise + it.width + HOLD_CLKS;
    wait_until(end_b - 5);
    trig = 1'b1;
    wait_until(end_b + 20);
    check("held_no_busy", busy, 0);
    trig = 1'b0;
    repeat (3) @(negedge clk);
    measure(7, TRIG_CLKS + 2, K_ECHO, 1'b0, tr);

    for (int i = 0; i < 25; i++) begin
      int w;
      if ($urandom_range(9, 0) < 7) w = int'($urandom_range(TRIG_CLKS + 4, TRIG_CLKS));
      else w = int'($urandom_range(TRIG_CLKS - 1, 1));
      repeat ($urandom_range(3, 0)) @(negedge clk);
      measure(int'($urandom_range(MAXCM + 3, 0)), w, K_ECHO, 1'($urandom_range(1, 0)), tr);
    end

    repeat (20) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
